trap_ctrl: RTL and testbench

- Machine-mode trap sequencer that sits between the commit stage and the csr unit.
- Owns mstatus (MIE/MPIE only), mie and mip; synchronises the three machine interrupt lines; chooses between interrupts and synchronous exceptions.
- Runs a flush/drain handshake with the pipeline, then issues one trap request per event to the csr unit, which writes mepc/mcause/mtval and redirects to mtvec.
- Also performs the mstatus side of mret.

---
 rtl/trap_ctrl_pkg.sv | 38 +++
 rtl/trap_ctrl_if.sv | 32 +++
 rtl/trap_ctrl_irq_sync.sv | 18 +
 rtl/trap_ctrl.sv | 118 +++++++++++
 tb/tb_trap_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared CSR addresses, field positions and types for the machine-mode trap sequencer.
package trap_ctrl_pkg;
    localparam int Xlen = 32;

    localparam logic [11:0] CSRmstatus = 12'h300;
    localparam logic [11:0] CSRmie     = 12'h304;
    localparam logic [11:0] CSRmip     = 12'h344;

    localparam int MstatusMie  = 3;
    localparam int MstatusMpie = 7;

    localparam int IrqMSoft  = 3;
    localparam int IrqMTimer = 7;
    localparam int IrqMExt   = 11;

    localparam logic [Xlen-1:0] MieMask = Xlen'(12'h888);

    typedef enum logic [1:0] {TrapIdle, TrapDrain, TrapIssue} trap_state_e;

    typedef enum logic [4:0] {
        ExcInstrMisalign = 5'd0,  ExcInstrFault   = 5'd1,  ExcIllegal      = 5'd2,
        ExcBreak         = 5'd3,  ExcLoadMisalign = 5'd4,  ExcLoadFault    = 5'd5,
        ExcStoreMisalign = 5'd6,  ExcStoreFault   = 5'd7,  ExcEcallU       = 5'd8,
        ExcEcallM        = 5'd11, ExcInstrPage    = 5'd12, ExcLoadPage     = 5'd13,
        ExcStorePage     = 5'd15
    } csr_mcause_e;

    // Interrupt mcause with MEI > MSI > MTI priority; caller guarantees one is active.
    function automatic logic [Xlen-1:0] irq_cause(input logic ext, input logic sw);
        logic [Xlen-1:0] c;
        c = '0;
        c[Xlen-1] = 1'b1;
        if (ext)     c[3:0] = 4'(IrqMExt);
        else if (sw) c[3:0] = 4'(IrqMSoft);
        else         c[3:0] = 4'(IrqMTimer);
        return c;
    endfunction
endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-stage, pipeline-flush and csr-unit signals of the trap sequencer.
interface trap_ctrl_if;
    logic                          instr_valid_i;
    logic                          instr_ready_o;
    logic                          expt_valid_i;
    trap_ctrl_pkg::csr_mcause_e    expt_cause_i;
    logic                          mret_i;
    logic                          csr_we_i;
    logic [11:0]                   csr_addr_i;
    logic [trap_ctrl_pkg::Xlen-1:0] csr_wdata_i;
    logic                          csr_hit_o;
    logic [trap_ctrl_pkg::Xlen-1:0] csr_rdata_o;
    logic                          flush_o;
    logic                          flush_ack_i;
    logic                          trap_valid_o;
    logic [trap_ctrl_pkg::Xlen-1:0] trap_cause_o;
    logic                          trap_is_irq_o;

    modport slave (
        input  instr_valid_i, expt_valid_i, expt_cause_i, mret_i, csr_we_i,
               csr_addr_i, csr_wdata_i, flush_ack_i,
        output instr_ready_o, csr_hit_o, csr_rdata_o, flush_o, trap_valid_o,
               trap_cause_o, trap_is_irq_o
    );

    modport master (
        output instr_valid_i, expt_valid_i, expt_cause_i, mret_i, csr_we_i,
               csr_addr_i, csr_wdata_i, flush_ack_i,
        input  instr_ready_o, csr_hit_o, csr_rdata_o, flush_o, trap_valid_o,
               trap_cause_o, trap_is_irq_o
    );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser for the three asynchronous machine interrupt levels.
module irq_sync #(
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);
    logic [SyncStages-1:0][2:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ff_q <= '0;
        else         ff_q <= {ff_q[SyncStages-2:0], d_i};
    end

    assign q_o = ff_q[SyncStages-1];
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns mstatus.MIE/MPIE, mie, mip and runs the
// flush/drain handshake before issuing one trap request per event.
module trap_ctrl import trap_ctrl_pkg::*; #(
    parameter int   SyncStages = 2,
    parameter logic ResetMie   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    trap_ctrl_if.slave  bus
);
    trap_state_e     state_q, state_d;
    logic [2:0]      irq_q;
    logic            mie_bit_q, mpie_q, is_irq_q;
    logic [Xlen-1:0] mie_q, mip, mstatus, act, cause_q;
    logic            irq_pend, take, ready, flush, tvalid;
    logic            unused_wdata;

    irq_sync #(.SyncStages(SyncStages)) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   ({irq_ext_i, irq_timer_i, irq_sw_i}),
        .q_o   (irq_q)
    );

    always_comb begin
        mip = '0;
        mip[IrqMSoft]  = irq_q[0];
        mip[IrqMTimer] = irq_q[1];
        mip[IrqMExt]   = irq_q[2];
        mstatus = '0;
        mstatus[MstatusMie]  = mie_bit_q;
        mstatus[MstatusMpie] = mpie_q;
    end

    assign act      = mip & mie_q;
    assign irq_pend = mie_bit_q & (|act);
    assign take     = (state_q == TrapIdle) && bus.instr_valid_i && (irq_pend || bus.expt_valid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= TrapIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        flush   = 1'b0;
        tvalid  = 1'b0;
        case (state_q)
            TrapIdle: begin
                // the accepted instruction is squashed, so it must not retire
                ready = !take;
                if (take) state_d = TrapDrain;
            end
            TrapDrain: begin
                flush = 1'b1;
                if (bus.flush_ack_i) state_d = TrapIssue;
            end
            TrapIssue: begin
                tvalid  = 1'b1;
                state_d = TrapIdle;
            end
            default: state_d = TrapIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_bit_q <= ResetMie;
            mpie_q    <= 1'b0;
            mie_q     <= '0;
            cause_q   <= '0;
            is_irq_q  <= 1'b0;
        end else if (state_q == TrapIssue) begin
            mpie_q    <= mie_bit_q;
            mie_bit_q <= 1'b0;
        end else if (state_q == TrapIdle) begin
            if (take) begin
                cause_q  <= irq_pend ? irq_cause(act[IrqMExt], act[IrqMSoft])
                                     : Xlen'(bus.expt_cause_i);
                is_irq_q <= irq_pend;
            end else if (bus.mret_i) begin
                mie_bit_q <= mpie_q;
                mpie_q    <= 1'b1;
            end else if (bus.csr_we_i) begin
                case (bus.csr_addr_i)
                    CSRmstatus: begin
                        mie_bit_q <= bus.csr_wdata_i[MstatusMie];
                        mpie_q    <= bus.csr_wdata_i[MstatusMpie];
                    end
                    CSRmie:  mie_q <= bus.csr_wdata_i & MieMask;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.csr_hit_o   = 1'b1;
        bus.csr_rdata_o = '0;
        case (bus.csr_addr_i)
            CSRmstatus: bus.csr_rdata_o = mstatus;
            CSRmie:     bus.csr_rdata_o = mie_q;
            CSRmip:     bus.csr_rdata_o = mip;
            default:    bus.csr_hit_o   = 1'b0;
        endcase
    end

    assign unused_wdata      = ^bus.csr_wdata_i;
    assign bus.instr_ready_o = ready;
    assign bus.flush_o       = flush;
    assign bus.trap_valid_o  = tvalid;
    assign bus.trap_cause_o  = cause_q;
    assign bus.trap_is_irq_o = is_irq_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed test-plan scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq_sw = 1'b0, irq_tmr = 1'b0, irq_ext = 1'b0;
    int   n_chk = 0, n_err = 0, tv_cnt = 0;
    logic o_flush, o_ready;
    logic [31:0] o_rdata;

    trap_ctrl_if bus();

    trap_ctrl #(.SyncStages(SYNC), .ResetMie(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .irq_sw_i(irq_sw), .irq_timer_i(irq_tmr),
        .irq_ext_i(irq_ext), .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: architectural fields plus a trap-in-flight record
    logic [2:0]  m_hist[$];
    bit          m_mieb, m_mpie, m_drain, m_issue, m_irq;
    logic [31:0] m_mie, m_cause;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(3'b000);
        m_mieb = 1'b0; m_mpie = 1'b0; m_drain = 1'b0; m_issue = 1'b0; m_irq = 1'b0;
        m_mie = '0; m_cause = '0;
    endtask

    // one clock: drive, check outputs against the model, advance the model
    task automatic step(input logic iv, input logic ex, input logic [4:0] ec, input logic mr,
                        input logic we, input logic [11:0] a, input logic [31:0] wd, input logic ack);
        logic [2:0]  vis;
        logic [31:0] mip, act, mst, rd;
        bit          pend, idle, take, hit;
        @(negedge clk);
        bus.instr_valid_i = iv; bus.expt_valid_i = ex; bus.expt_cause_i = csr_mcause_e'(ec);
        bus.mret_i = mr; bus.csr_we_i = we; bus.csr_addr_i = a; bus.csr_wdata_i = wd;
        bus.flush_ack_i = ack;
        #1;
        vis = m_hist[0];
        mip = (32'(vis[0]) << 3) | (32'(vis[1]) << 7) | (32'(vis[2]) << 11);
        act = mip & m_mie;
        pend = m_mieb && (act != 0);
        idle = !m_drain && !m_issue;
        take = idle && iv && (pend || ex);
        mst = (m_mieb ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
        hit = 1'b1;
        case (a)
            12'h300: rd = mst;
            12'h304: rd = m_mie;
            12'h344: rd = mip;
            default: begin rd = 0; hit = 1'b0; end
        endcase
        chk("ready", 32'(bus.instr_ready_o), 32'(idle && !take));
        chk("flush", 32'(bus.flush_o), 32'(m_drain));
        chk("trap_valid", 32'(bus.trap_valid_o), 32'(m_issue));
        chk("cause", bus.trap_cause_o, m_cause);
        chk("is_irq", 32'(bus.trap_is_irq_o), 32'(m_irq));
        chk("hit", 32'(bus.csr_hit_o), 32'(hit));
        chk("rdata", bus.csr_rdata_o, rd);
        o_flush = bus.flush_o; o_ready = bus.instr_ready_o; o_rdata = bus.csr_rdata_o;
        if (bus.trap_valid_o) tv_cnt++;
        if (m_issue) begin
            m_mpie = m_mieb; m_mieb = 1'b0; m_issue = 1'b0;
        end else if (m_drain) begin
            if (ack) begin m_drain = 1'b0; m_issue = 1'b1; end
        end else if (take) begin
            m_drain = 1'b1;
            m_irq = pend;
            if (pend) m_cause = 32'h8000_0000 | (act[11] ? 32'd11 : act[3] ? 32'd3 : 32'd7);
            else      m_cause = 32'(ec);
        end else if (mr) begin
            m_mieb = m_mpie; m_mpie = 1'b1;
        end else if (we) begin
            if (a == 12'h300) begin m_mieb = wd[3]; m_mpie = wd[7]; end
            else if (a == 12'h304) m_mie = wd & 32'h888;
        end
        m_hist.push_back({irq_ext, irq_tmr, irq_sw});
        void'(m_hist.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [11:0] a);
        step(0, 0, 0, 0, 0, a, 0, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(0, 0, 0, 0, 1, a, d, 0);
    endtask

    // accept, drain with immediate ack, issue
    task automatic fire(input logic ex, input logic [4:0] ec, input logic we, input logic [31:0] wd);
        step(1, ex, ec, 0, we, 12'h300, wd, 0);
        step(0, 0, 0, 0, 0, 12'h300, 0, 1);
        idle(12'h300);
    endtask

    initial begin
        logic [4:0]  codes [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 15};
        logic [11:0] addrs [4]  = '{12'h300, 12'h304, 12'h344, 12'h305};
        bus.instr_valid_i = 0; bus.expt_valid_i = 0; bus.expt_cause_i = ExcInstrMisalign;
        bus.mret_i = 0; bus.csr_we_i = 0; bus.csr_addr_i = 12'h300; bus.csr_wdata_i = 0;
        bus.flush_ack_i = 0;
        m_reset();
        #12;
        chk("rst_flush", 32'(bus.flush_o), 0);
        chk("rst_tv", 32'(bus.trap_valid_o), 0);
        chk("rst_cause", bus.trap_cause_o, 0);
        chk("rst_irq", 32'(bus.trap_is_irq_o), 0);
        chk("rst_ready", 32'(bus.instr_ready_o), 1);
        chk("rst_mstatus", bus.csr_rdata_o, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // timer interrupt, slow ack
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h8);
        irq_tmr = 1'b1;
        step(1, 0, 0, 0, 0, 12'h344, 0, 0);
        step(1, 0, 0, 0, 0, 12'h344, 0, 0);
        step(1, 0, 0, 0, 0, 12'h344, 0, 0);
        chk("tmr_mip", o_rdata, 32'h80);
        idle(12'h344);
        chk("tmr_flush", 32'(o_flush), 1);
        idle(12'h344); idle(12'h344);
        tv_cnt = 0;
        step(0, 0, 0, 0, 0, 12'h300, 0, 1);
        idle(12'h300); idle(12'h300);
        chk("tmr_tv_cnt", 32'(tv_cnt), 1);
        chk("tmr_cause", bus.trap_cause_o, 32'h8000_0007);
        chk("tmr_is_irq", 32'(bus.trap_is_irq_o), 1);
        chk("tmr_mstatus", o_rdata, 32'h80);

        // priority: all three, then sw+timer
        wr(12'h300, 32'h8);
        irq_sw = 1'b1; irq_ext = 1'b1;
        idle(12'h300); idle(12'h300);
        fire(0, 0, 0, 0);
        chk("prio_ext", bus.trap_cause_o, 32'h8000_000B);
        irq_ext = 1'b0;
        idle(12'h300); idle(12'h300);
        step(0, 0, 0, 1, 0, 12'h300, 0, 0);
        fire(0, 0, 0, 0);
        chk("prio_sw", bus.trap_cause_o, 32'h8000_0003);
        irq_sw = 1'b0;
        idle(12'h300); idle(12'h300);

        // exception vs pending timer, then with MIE clear
        step(0, 0, 0, 1, 0, 12'h300, 0, 0);
        fire(1, 5'd2, 0, 0);
        chk("exc_irq_wins", bus.trap_cause_o, 32'h8000_0007);
        fire(1, 5'd2, 0, 0);
        chk("exc_cause", bus.trap_cause_o, 32'h2);
        chk("exc_is_irq", 32'(bus.trap_is_irq_o), 0);

        // trap then mret
        wr(12'h300, 32'h8);
        fire(1, 5'd2, 0, 0);
        idle(12'h300);
        chk("mret_before", o_rdata, 32'h80);
        step(0, 0, 0, 1, 0, 12'h300, 0, 0);
        chk("mret_noflush", 32'(o_flush), 0);
        idle(12'h300);
        chk("mret_after", o_rdata, 32'h88);

        // CSR write on the accepting cycle is squashed
        fire(0, 0, 1, 32'h0);
        idle(12'h300);
        chk("squash_mstatus", o_rdata, 32'h80);

        // reset mid-drain
        wr(12'h300, 32'h8);
        step(1, 0, 0, 0, 0, 12'h300, 0, 0);
        irq_tmr = 1'b0;
        bus.instr_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstd_flush", 32'(bus.flush_o), 0);
        chk("rstd_ready", 32'(bus.instr_ready_o), 1);
        m_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tv_cnt = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 12'h300, 0, 1);
        chk("rstd_mstatus", o_rdata, 0);
        chk("rstd_no_tv", 32'(tv_cnt), 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic mr, we;
            if ($urandom_range(0, 15) == 0) irq_sw  = ~irq_sw;
            if ($urandom_range(0, 15) == 0) irq_tmr = ~irq_tmr;
            if ($urandom_range(0, 15) == 0) irq_ext = ~irq_ext;
            mr = ($urandom_range(0, 7) == 0);
            we = !mr && ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 codes[$urandom_range(0, 12)], mr, we, addrs[$urandom_range(0, 3)],
                 $urandom, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
